// File: rtl/sr_pkg.sv
// Shared definitions for the SR flip-flop bank: S=R=1 mode encodings and
// the per-bit next-state rule.
package sr_pkg;

  typedef enum logic [1:0] {
    SR_HOLD    = 2'd0,
    SR_TOGGLE  = 2'd1,
    SR_SET_DOM = 2'd2,
    SR_RST_DOM = 2'd3
  } sr_mode_e;

  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input sr_mode_e mode);
    logic nq;
    nq = q;
    case ({s, r})
      2'b00: nq = q;
      2'b01: nq = 1'b0;
      2'b10: nq = 1'b1;
      default: begin
        case (mode)
          SR_HOLD:    nq = q;
          SR_TOGGLE:  nq = ~q;
          SR_SET_DOM: nq = 1'b1;
          default:    nq = 1'b0;
        endcase
      end
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// Single-bit SR register with async active-low reset to a supplied value and
// a registered flag marking an S=R=1 sample.
module sr_cell
  import sr_pkg::*;
#(
  parameter sr_mode_e MODE = SR_HOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic s,
  input  logic r,
  output logic q,
  output logic invalid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= rst_val;
      invalid <= 1'b0;
    end else begin
      q       <= sr_next(q, s, r, MODE);
      invalid <= s & r;
    end
  end

endmodule

// File: rtl/sr_flipflop.sv
// Bank of WIDTH independent rising-edge SR flip-flops with complementary
// outputs and a per-bit illegal-input (S=R=1) pulse.
module sr_flipflop
  import sr_pkg::*;
#(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              BOTH_MODE = 0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] Invalid
);

  if ((WIDTH < 1) || (WIDTH > 64) || (BOTH_MODE < 0) || (BOTH_MODE > 3)) begin : g_param_check
    $error("sr_flipflop: illegal WIDTH or BOTH_MODE");
  end

  localparam sr_mode_e MODE = sr_mode_e'(BOTH_MODE[1:0]);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_cell #(
      .MODE(MODE)
    ) u_cell (
      .clk    (Clk),
      .rst_n  (Rst_n),
      .rst_val(RESET_VAL[i]),
      .s      (S[i]),
      .r      (R[i]),
      .q      (Q[i]),
      .invalid(Invalid[i])
    );
  end

  // Qn comes straight off the Q flops so it tracks Q through reset as well.
  assign Qn = ~Q;

endmodule

// File: tb/tb_sr_flipflop.sv
// Self-checking bench: one 1-bit bank plus four 4-bit banks (one per BOTH_MODE).
module tb_sr_flipflop;

  logic       clk;
  logic       rst_n;
  logic       s1, r1;
  logic [3:0] s4, r4;
  logic       q1, qn1, inv1;
  logic [3:0] q4[4];
  logic [3:0] qn4[4];
  logic [3:0] inv4[4];

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sr_flipflop #(
    .WIDTH    (1),
    .RESET_VAL(1'b0),
    .BOTH_MODE(0)
  ) u_w1 (
    .Clk    (clk),
    .Rst_n  (rst_n),
    .S      (s1),
    .R      (r1),
    .Q      (q1),
    .Qn     (qn1),
    .Invalid(inv1)
  );

  for (genvar k = 0; k < 4; k++) begin : g_mode
    sr_flipflop #(
      .WIDTH    (4),
      .RESET_VAL(4'b1010),
      .BOTH_MODE(k)
    ) u_w4 (
      .Clk    (clk),
      .Rst_n  (rst_n),
      .S      (s4),
      .R      (r4),
      .Q      (q4[k]),
      .Qn     (qn4[k]),
      .Invalid(inv4[k])
    );
  end

  // Vector form of the SR rules: hold where idle, set/clear where exactly
  // one request is active, mode-selected value where both are.
  function automatic logic [3:0] model_next(input logic [3:0] q, input logic [3:0] s,
                                            input logic [3:0] r, input int mode);
    logic [3:0] bv;
    case (mode)
      0:       bv = q;
      1:       bv = ~q;
      2:       bv = 4'b1111;
      default: bv = 4'b0000;
    endcase
    return (q & ~s & ~r) | (s & ~r) | (s & r & bv);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; s1 = 1'b1; r1 = 1'b0; s4 = 4'b1111; r4 = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({q1, qn1, inv1} !== 3'b010) begin
      failures++;
      $display("FAIL reset_w1 got q/qn/inv=%b%b%b expected 010", q1, qn1, inv1);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({q4[k], qn4[k], inv4[k]} !== 12'b1010_0101_0000) begin
        failures++;
        $display("FAIL reset_w4 mode=%0d got q=%b qn=%b inv=%b expected 1010 0101 0000",
                 k, q4[k], qn4[k], inv4[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; s1 = 1'b0; r1 = 1'b0; s4 = '0; r4 = '0;
    @(posedge clk);
    #1;
    checks++;
    if ({q1, qn1, inv1} !== 3'b010) begin
      failures++;
      $display("FAIL reset_hold_w1 got q/qn/inv=%b%b%b expected 010", q1, qn1, inv1);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q4[k] !== 4'b1010) begin
        failures++;
        $display("FAIL reset_hold_w4 mode=%0d got q=%b expected 1010", k, q4[k]);
      end
    end
  endtask

  task automatic test_basic();
    logic [1:0] sr_seq[5];
    logic       exp_q[5];
    logic       exp_inv[5];
    sr_seq  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    exp_q   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_inv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      {s1, r1} = sr_seq[i];
      @(posedge clk);
      #1;
      checks++;
      if ({q1, qn1, inv1} !== {exp_q[i], ~exp_q[i], exp_inv[i]}) begin
        failures++;
        $display("FAIL basic_step%0d got q/qn/inv=%b%b%b expected %b%b%b",
                 i, q1, qn1, inv1, exp_q[i], ~exp_q[i], exp_inv[i]);
      end
    end
    @(negedge clk);
    s1 = 1'b0; r1 = 1'b0;
  endtask

  task automatic test_modes();
    logic [3:0] exp_q[4];
    exp_q = '{4'b1111, 4'b1110, 4'b1111, 4'b1110};
    @(negedge clk);
    s4 = 4'b1111; r4 = 4'b0000;
    @(negedge clk);
    s4 = 4'b0001; r4 = 4'b0001;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({q4[k], qn4[k], inv4[k]} !== {exp_q[k], ~exp_q[k], 4'b0001}) begin
        failures++;
        $display("FAIL modes mode=%0d got q=%b qn=%b inv=%b expected q=%b inv=0001",
                 k, q4[k], qn4[k], inv4[k], exp_q[k]);
      end
    end
    @(negedge clk);
    s4 = '0; r4 = '0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({q4[k], inv4[k]} !== {exp_q[k], 4'b0000}) begin
        failures++;
        $display("FAIL modes_clear mode=%0d got q=%b inv=%b expected q=%b inv=0000",
                 k, q4[k], inv4[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_multibit();
    logic [3:0] exp_q[4];
    test_reset();
    @(negedge clk);
    s4 = 4'b0001; r4 = 4'b1000;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({q4[k], inv4[k]} !== {4'b0011, 4'b0000}) begin
        failures++;
        $display("FAIL multibit_sr mode=%0d got q=%b inv=%b expected q=0011 inv=0000",
                 k, q4[k], inv4[k]);
      end
    end
    exp_q = '{4'b0011, 4'b0111, 4'b0111, 4'b0011};
    @(negedge clk);
    s4 = 4'b0100; r4 = 4'b0100;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({q4[k], qn4[k], inv4[k]} !== {exp_q[k], ~exp_q[k], 4'b0100}) begin
        failures++;
        $display("FAIL multibit_both mode=%0d got q=%b qn=%b inv=%b expected q=%b inv=0100",
                 k, q4[k], qn4[k], inv4[k], exp_q[k]);
      end
    end
    @(negedge clk);
    s4 = '0; r4 = '0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    s1 = 1'b1; r1 = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (q1 !== 1'b1) begin
      failures++;
      $display("FAIL async_preset got q=%b expected 1", q1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({q1, qn1, inv1} !== 3'b010) begin
      failures++;
      $display("FAIL async_assert got q/qn/inv=%b%b%b expected 010", q1, qn1, inv1);
    end
    checks++;
    if (q4[0] !== 4'b1010) begin
      failures++;
      $display("FAIL async_assert_w4 got q=%b expected 1010", q4[0]);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({q1, qn1} !== 2'b01) begin
      failures++;
      $display("FAIL async_held got q/qn=%b%b expected 01", q1, qn1);
    end
    @(negedge clk);
    rst_n = 1'b1; s1 = 1'b0;
  endtask

  task automatic test_random();
    logic       m1, mi1;
    logic [3:0] mq[4];
    logic [3:0] mi[4];
    logic [3:0] n1;
    test_reset();
    m1 = 1'b0; mi1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mq[k] = q4[k] === 4'b1010 ? 4'b1010 : 4'b1010;
      mi[k] = 4'b0000;
    end
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 15) != 0);
      s1 = 1'($urandom); r1 = 1'($urandom);
      s4 = 4'($urandom); r4 = 4'($urandom);
      if (!rst_n) begin
        m1 = 1'b0; mi1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
          mq[k] = 4'b1010; mi[k] = 4'b0000;
        end
      end
      @(posedge clk);
      if (rst_n) begin
        n1  = model_next({3'b000, m1}, {3'b000, s1}, {3'b000, r1}, 0);
        m1  = n1[0];
        mi1 = s1 & r1;
        for (int k = 0; k < 4; k++) begin
          mq[k] = model_next(mq[k], s4, r4, k);
          mi[k] = s4 & r4;
        end
      end
      #1;
      checks++;
      if ({q1, qn1, inv1} !== {m1, ~m1, mi1}) begin
        failures++;
        $display("FAIL random_w1 cycle=%0d got q/qn/inv=%b%b%b expected %b%b%b",
                 n, q1, qn1, inv1, m1, ~m1, mi1);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ({q4[k], qn4[k], inv4[k]} !== {mq[k], ~mq[k], mi[k]}) begin
          failures++;
          $display("FAIL random_w4 cycle=%0d mode=%0d got q=%b qn=%b inv=%b expected q=%b qn=%b inv=%b",
                   n, k, q4[k], qn4[k], inv4[k], mq[k], ~mq[k], mi[k]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    s1 = 1'b0; r1 = 1'b0; s4 = '0; r4 = '0;
    test_reset();
    test_basic();
    test_modes();
    test_multibit();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
